iic_slave_regif: RTL and testbench
==================================

// Module: iic_slave_regif
// PURPOSE
//  I2C target (responder) end of the board I2C bus. Decodes START/addr/reg-addr/data/STOP
//  sequences from an external master and drives a simple 8-bit register-file port.
//  Lets FPGA status/config registers be reached over the same bus protocol the init cores
//  use as master (write: S,addr+W,reg,data,P; read: S,addr+W,reg,Sr|P+S,addr+R,data,NACK,P).
// PARAMETERS
//  SLAVE_ADDR  7'b111_0001  7-bit bus address this block answers to
//  FILTER_LEN  3            CLK samples an SCL/SDA level must hold before accepted (1..7)
// PORTS
//  CLK        in   1  system clock (50 MHz nominal; SCL <= 400 kHz)
//  RSTn       in   1  reset, asynchronous, active-low
//  SCL        in   1  bus clock from master (no clock stretching)
//  SDA        inout 1 bus data; open-drain: driven 1'b0 or 1'bz only
//  reg_addr   out  8  current register pointer
//  reg_wdata  out  8  write data, valid while reg_we=1
//  reg_we     out  1  one-CLK write strobe
//  reg_re     out  1  one-CLK read-fetch strobe
//  reg_rdata  in   8  read data, sampled exactly 1 CLK after reg_re
//  busy       out  1  high from accepted address match to STOP/START/NACK
// BEHAVIOUR
//  Reset: reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, SDA=z, state IDLE.
//   Async reset mid-transfer releases SDA in the same instant; bus recovers on next START.
//  Front end: 2-flop sync + FILTER_LEN-sample stable filter per line; edge pulses scl_rise,
//   scl_fall. START = filtered SDA 1->0 while SCL=1; STOP = SDA 0->1 while SCL=1.
//  Bits sampled on scl_rise (MSB first); SDA output changed only on scl_fall.
//  States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
//   IDLE --START--> ADDR (bit count 0).
//   ADDR: 8 bits; addr match -> ADDR_ACK (SDA low one SCL period), busy=1; else IGNORE.
//   ADDR_ACK: R/W=0 -> REG; R/W=1 -> reg_re pulse on the ACK scl_fall, latch reg_rdata
//    next CLK into tx shifter, -> RDATA.
//   REG: 8 bits -> reg_addr loaded on 8th scl_rise; ACK -> WDATA.
//   WDATA: 8 bits -> reg_wdata loaded, reg_we pulses on 8th scl_rise; ACK -> WDATA_ACK.
//   RDATA: drive tx bits (release SDA for 1s); -> RDATA_ACK, sample master ACK on scl_rise.
//    ACK(0): pointer update, reg_re, reload, -> RDATA. NACK(1): release SDA -> IGNORE.
//   IGNORE: SDA=z, wait for START (->ADDR) or STOP (->IDLE).
//  START in any state (repeated start) -> ADDR, bit count 0, SDA released, reg_addr kept.
//  STOP in any state -> IDLE, busy=0, SDA released; partial byte discarded, no reg_we.
//  reg_we and reg_re never asserted in same CLK; a given byte strobes at most once.
//  Pointer arithmetic modulo 256 (0xFF+1 -> 0x00).
// CONFIGURATION
//  IIC_SLV_AUTOINC_EN defined: reg_addr increments by 1 after every reg_we and after every
//   master-ACKed read byte -> multi-byte burst read/write supported.
//  Not defined: reg_addr changes only in REG state; further data bytes in a burst write
//   rewrite the same register; burst reads return the same register repeatedly.
// STRUCTURE
//  iic_pkg: shared state encodings, iic_nop/write/read command codes (used by master cores),
//   ACK/NACK level constants, default SLAVE_ADDR.
//  Sub-module iic_line_filter (sync + FILTER_LEN filter + rise/fall pulses), instanced for
//   SCL and SDA. FSM, shifters, pointer in this module.
// TESTING (bench: codebase basic_iic master, slave_addr 7'b111_0001, F250K 200, pull-ups)
//  Write reg 0xE6 <= 0x10 -> single reg_we, reg_addr=0xE6, reg_wdata=0x10; master Done.
//  Read reg 0xDA, model returns 0x04 -> reg_re once, master RdData=0x04, final NACK -> IDLE.
//  Frame to addr 7'b111_0000 -> no ACK, SDA never driven low by DUT, no strobes, busy=0.
//  AUTOINC_EN: write 0xFF,0xAA,0xBB -> reg_we at 0xFF then 0x00; without: both at 0xFF.
//  Repeated START after reg byte then addr+R -> read from latched pointer, no reg_we.
//  RSTn low during RDATA driving 0 -> SDA z immediately; next write frame completes normally.

Source files
------------

// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared I2C state encodings, master command codes and bus constants
package iic_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } iic_state_t;

  typedef enum logic [1:0] {
    IIC_NOP   = 2'd0,
    IIC_WRITE = 2'd1,
    IIC_READ  = 2'd2
  } iic_cmd_t;

  localparam logic       IIC_ACK            = 1'b0;
  localparam logic       IIC_NACK           = 1'b1;
  localparam logic [6:0] IIC_DEF_SLAVE_ADDR = 7'b111_0001;

endpackage

// File: rtl/iic_line_filter.sv
// rtl/iic_line_filter.sv - 2-flop synchroniser, FILTER_LEN stability filter and edge pulses
module iic_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic line_in,
  output logic line_f,
  output logic rise,
  output logic fall
);

  localparam logic [2:0] CNT_LAST = 3'(FILTER_LEN - 1);

  logic [1:0] sync;
  logic [2:0] cnt;

  // Idle bus level is high, so the filter resets to 1 to avoid a false START.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync   <= 2'b11;
      cnt    <= '0;
      line_f <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync <= {sync[0], line_in};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == line_f) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        line_f <= sync[1];
        rise   <= sync[1];
        fall   <= ~sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/iic_slave_regif.sv
// rtl/iic_slave_regif.sv - I2C target driving an 8-bit register port; IIC_SLV_AUTOINC_EN enables pointer auto-increment
import iic_pkg::*;

module iic_slave_regif #(
  parameter logic [6:0] SLAVE_ADDR = IIC_DEF_SLAVE_ADDR,
  parameter int         FILTER_LEN = 3
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

`ifdef IIC_SLV_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic start_det, stop_det;

  iic_state_t state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] rx_sh, rx_sh_nxt, rx_byte;
  logic [7:0] tx_sh, tx_sh_nxt;
  logic [7:0] reg_addr_nxt, reg_wdata_nxt;
  logic       sda_oe, sda_oe_nxt;
  logic       ack_drv, ack_drv_nxt;
  logic       rd_mode, rd_mode_nxt;
  logic       fetch_req, fetch_nxt;
  logic       reg_we_nxt, busy_nxt;
  logic       re_d;

  iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .CLK(CLK), .RSTn(RSTn), .line_in(SCL), .line_f(scl_f), .rise(scl_rise), .fall(scl_fall)
  );

  iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .CLK(CLK), .RSTn(RSTn), .line_in(SDA), .line_f(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  assign SDA       = sda_oe ? 1'b0 : 1'bz;
  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;
  assign rx_byte   = {rx_sh[6:0], sda_f};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      re_d      <= 1'b0;
      fetch_req <= 1'b0;
      sda_oe    <= 1'b0;
      ack_drv   <= 1'b0;
      rd_mode   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      rx_sh     <= rx_sh_nxt;
      tx_sh     <= tx_sh_nxt;
      reg_addr  <= reg_addr_nxt;
      reg_wdata <= reg_wdata_nxt;
      reg_we    <= reg_we_nxt;
      reg_re    <= fetch_req;
      re_d      <= reg_re;
      fetch_req <= fetch_nxt;
      sda_oe    <= sda_oe_nxt;
      ack_drv   <= ack_drv_nxt;
      rd_mode   <= rd_mode_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    rx_sh_nxt     = rx_sh;
    tx_sh_nxt     = tx_sh;
    reg_addr_nxt  = reg_addr;
    reg_wdata_nxt = reg_wdata;
    reg_we_nxt    = 1'b0;
    fetch_nxt     = 1'b0;
    sda_oe_nxt    = sda_oe;
    ack_drv_nxt   = ack_drv;
    rd_mode_nxt   = rd_mode;
    busy_nxt      = busy;

    // Read data arrives the cycle after reg_re; pick it up into the shifter then.
    if (re_d) tx_sh_nxt = reg_rdata;
    if (AUTOINC && reg_we) reg_addr_nxt = reg_addr + 8'd1;

    case (state)
      ST_ADDR, ST_REG, ST_WDATA: begin
        if (scl_rise) begin
          rx_sh_nxt   = rx_byte;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ack_drv_nxt = 1'b0;
            if (state == ST_ADDR) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_nxt   = ST_ADDR_ACK;
                busy_nxt    = 1'b1;
                rd_mode_nxt = rx_byte[0];
              end else begin
                state_nxt = ST_IGNORE;
              end
            end else if (state == ST_REG) begin
              reg_addr_nxt = rx_byte;
              state_nxt    = ST_REG_ACK;
            end else begin
              reg_wdata_nxt = rx_byte;
              reg_we_nxt    = 1'b1;
              state_nxt     = ST_WDATA_ACK;
            end
          end
        end
      end
      // First SCL fall after the byte starts our ACK, the next one ends it.
      ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
        if (scl_fall) begin
          if (!ack_drv) begin
            ack_drv_nxt = 1'b1;
            sda_oe_nxt  = 1'b1;
            if (state == ST_ADDR_ACK && rd_mode) fetch_nxt = 1'b1;
          end else begin
            ack_drv_nxt = 1'b0;
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
            if (state == ST_ADDR_ACK && rd_mode) begin
              state_nxt  = ST_RDATA;
              sda_oe_nxt = ~tx_sh[7];
              tx_sh_nxt  = {tx_sh[6:0], 1'b1};
            end else if (state == ST_ADDR_ACK) begin
              state_nxt = ST_REG;
            end else begin
              state_nxt = ST_WDATA;
            end
          end
        end
      end
      ST_RDATA: begin
        if (scl_fall) begin
          sda_oe_nxt = ~tx_sh[7];
          tx_sh_nxt  = {tx_sh[6:0], 1'b1};
        end
        if (scl_rise) begin
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt   = ST_RDATA_ACK;
            ack_drv_nxt = 1'b0;
          end
        end
      end
      // ack_drv here marks a master ACK seen; the following fall starts the next byte.
      ST_RDATA_ACK: begin
        if (scl_fall) begin
          if (!ack_drv) begin
            sda_oe_nxt = 1'b0;
          end else begin
            ack_drv_nxt = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = ST_RDATA;
            sda_oe_nxt  = ~tx_sh[7];
            tx_sh_nxt   = {tx_sh[6:0], 1'b1};
          end
        end
        if (scl_rise) begin
          if (sda_f == IIC_ACK) begin
            ack_drv_nxt = 1'b1;
            fetch_nxt   = 1'b1;
            if (AUTOINC) reg_addr_nxt = reg_addr + 8'd1;
          end else begin
            state_nxt = ST_IGNORE;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: ;
    endcase

    if (stop_det || start_det) begin
      state_nxt   = stop_det ? ST_IDLE : ST_ADDR;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      ack_drv_nxt = 1'b0;
      busy_nxt    = 1'b0;
      reg_we_nxt  = 1'b0;
      fetch_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_iic_slave_regif.sv
// tb/tb_iic_slave_regif.sv - scoreboard bench: bit-banged I2C master against iic_slave_regif
module tb_iic_slave_regif;

  localparam int Q = 50;

  typedef struct packed {
    logic       is_we;
    logic [7:0] addr;
    logic [7:0] data;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;
  logic [7:0] mem [256];
  sb_item_t   sb [$];
  int         vectors = 0;
  int         miscompares = 0;
  int         dut_low = 0;
  logic       watch_low = 1'b0;

  pullup pu_sda (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  iic_slave_regif dut (
    .CLK(clk), .RSTn(rst_n), .SCL(scl), .SDA(sda),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always @(posedge clk) if (reg_re) reg_rdata <= mem[reg_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every register strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && (reg_we || reg_re)) begin
      sb_item_t it;
      check("we_re_exclusive", 32'(reg_we & reg_re), 0);
      check("strobe_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        check("strobe_kind", 32'(reg_we), 32'(it.is_we));
        check("strobe_addr", 32'(reg_addr), 32'(it.addr));
        if (it.is_we) check("strobe_wdata", 32'(reg_wdata), 32'(it.data));
      end
    end
  end

  always @(negedge clk) if (watch_low && !m_oe && sda === 1'b0) dut_low++;

  task automatic qw();
    repeat (Q) @(negedge clk);
  endtask

  task automatic m_start();
    m_oe = 1'b0; qw();
    scl = 1'b1;  qw();
    m_oe = 1'b1; qw();
    scl = 1'b0;  qw();
  endtask

  task automatic m_stop();
    m_oe = 1'b1; qw();
    scl = 1'b1;  qw();
    m_oe = 1'b0; qw(); qw();
  endtask

  task automatic m_write(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_oe = ~b[i]; qw();
      scl = 1'b1;   qw(); qw();
      scl = 1'b0;
    end
    m_oe = 1'b0; qw();
    scl = 1'b1;  qw();
    ack = sda;   qw();
    scl = 1'b0;  qw();
  endtask

  task automatic m_read(input logic nack, output logic [7:0] b);
    m_oe = 1'b0;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      qw();
      scl = 1'b1; qw();
      b = {b[6:0], sda}; qw();
      scl = 1'b0;
    end
    m_oe = ~nack; qw();
    scl = 1'b1;   qw(); qw();
    scl = 1'b0;   qw();
    m_oe = 1'b0;
  endtask

  task automatic write_frame(input logic [7:0] ra, input logic [7:0] d0,
                             input logic [7:0] d1, input int nd);
    logic ack;
    m_start();
    m_write(8'hE2, ack); check("wr_addr_ack", 32'(ack), 0);
    check("wr_busy", 32'(busy), 1);
    m_write(ra, ack);    check("wr_reg_ack", 32'(ack), 0);
    m_write(d0, ack);    check("wr_d0_ack", 32'(ack), 0);
    if (nd > 1) begin
      m_write(d1, ack);  check("wr_d1_ack", 32'(ack), 0);
    end
    m_stop();
    check("wr_busy_after_stop", 32'(busy), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] rd;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'hDA] = 8'h04;
    mem[8'h35] = 8'h5A;
    mem[8'h36] = 8'hC3;
    mem[8'h40] = 8'h00;
    reg_rdata = 8'h00;

    repeat (5) @(negedge clk);
    check("rst_reg_addr", 32'(reg_addr), 0);
    check("rst_reg_wdata", 32'(reg_wdata), 0);
    check("rst_reg_we", 32'(reg_we), 0);
    check("rst_reg_re", 32'(reg_re), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sda", 32'(sda), 1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single write 0xE6 <= 0x10
    sb.push_back('{1'b1, 8'hE6, 8'h10});
    write_frame(8'hE6, 8'h10, 8'h00, 1);
    check("w1_reg_addr", 32'(reg_addr), 32'hE6);
    check("w1_reg_wdata", 32'(reg_wdata), 32'h10);
    check("w1_sb_drained", sb.size(), 0);

    // Read 0xDA via STOP then new START
    sb.push_back('{1'b0, 8'hDA, 8'h00});
    m_start();
    m_write(8'hE2, ack); check("r1_addrw_ack", 32'(ack), 0);
    m_write(8'hDA, ack); check("r1_reg_ack", 32'(ack), 0);
    m_stop();
    m_start();
    m_write(8'hE3, ack); check("r1_addrr_ack", 32'(ack), 0);
    m_read(1'b1, rd);    check("r1_rdata", 32'(rd), 32'h04);
    check("r1_busy_after_nack", 32'(busy), 0);
    m_stop();
    check("r1_sb_drained", sb.size(), 0);

    // Frame to a foreign address must be ignored entirely
    watch_low = 1'b1;
    m_start();
    m_write(8'hE0, ack); check("nm_addr_nack", 32'(ack), 1);
    check("nm_busy", 32'(busy), 0);
    m_write(8'h55, ack); check("nm_byte_nack", 32'(ack), 1);
    m_stop();
    watch_low = 1'b0;
    check("nm_sda_never_low", dut_low, 0);
    check("nm_reg_addr_kept", 32'(reg_addr), 32'hDA);

    // Burst write 0xFF: 0xAA, 0xBB
    sb.push_back('{1'b1, 8'hFF, 8'hAA});
`ifdef IIC_SLV_AUTOINC_EN
    sb.push_back('{1'b1, 8'h00, 8'hBB});
`else
    sb.push_back('{1'b1, 8'hFF, 8'hBB});
`endif
    write_frame(8'hFF, 8'hAA, 8'hBB, 2);
    check("bw_sb_drained", sb.size(), 0);

    // Repeated START after register byte, then two-byte read
    sb.push_back('{1'b0, 8'h35, 8'h00});
`ifdef IIC_SLV_AUTOINC_EN
    sb.push_back('{1'b0, 8'h36, 8'h00});
`else
    sb.push_back('{1'b0, 8'h35, 8'h00});
`endif
    m_start();
    m_write(8'hE2, ack); check("rs_addrw_ack", 32'(ack), 0);
    m_write(8'h35, ack); check("rs_reg_ack", 32'(ack), 0);
    m_start();
    m_write(8'hE3, ack); check("rs_addrr_ack", 32'(ack), 0);
    m_read(1'b0, rd);    check("rs_rdata0", 32'(rd), 32'h5A);
    m_read(1'b1, rd);
`ifdef IIC_SLV_AUTOINC_EN
    check("rs_rdata1", 32'(rd), 32'hC3);
    m_stop();
    check("rs_reg_addr", 32'(reg_addr), 32'h36);
`else
    check("rs_rdata1", 32'(rd), 32'h5A);
    m_stop();
    check("rs_reg_addr", 32'(reg_addr), 32'h35);
`endif
    check("rs_sb_drained", sb.size(), 0);

    // Async reset while the DUT drives a 0 data bit
    sb.push_back('{1'b0, 8'h40, 8'h00});
    m_start();
    m_write(8'hE2, ack); check("ar_addrw_ack", 32'(ack), 0);
    m_write(8'h40, ack); check("ar_reg_ack", 32'(ack), 0);
    m_start();
    m_write(8'hE3, ack); check("ar_addrr_ack", 32'(ack), 0);
    qw();
    check("ar_sda_driven_low", 32'(sda), 0);
    rst_n = 1'b0;
    #1;
    check("ar_sda_released", 32'(sda), 1);
    check("ar_busy", 32'(busy), 0);
    check("ar_reg_addr", 32'(reg_addr), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    m_stop();
    sb.push_back('{1'b1, 8'h12, 8'h34});
    write_frame(8'h12, 8'h34, 8'h00, 1);
    check("ar_w_reg_addr", 32'(reg_addr), 32'h12);
    check("ar_w_reg_wdata", 32'(reg_wdata), 32'h34);
    check("final_sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
